// File: rtl/n64_deblur_est_pkg.sv
// Shared definitions for the N64 deblur estimator: vdata_pre layout, gradient codes, defaults.
// Latency: none (declarations and constant functions only).
// Backpressure: none; the video stream is free-running.
package n64_deblur_est_pkg;

  // Default bits per colour channel on the video data bus.
  localparam int COLOR_W_DEF = 7;

  // Gradient codes {pre<cur, pre>cur}.
  localparam logic [1:0] GRAD_FLAT = 2'b00;
  localparam logic [1:0] GRAD_RISE = 2'b10;
  localparam logic [1:0] GRAD_FALL = 2'b01;

  // vdata_pre = {nVSYNC, nCLAMP, nHSYNC, nCSYNC, R, G, B}
  function automatic int idx_ncsync(input int cw);
    return 3 * cw;
  endfunction

  function automatic int idx_nvsync(input int cw);
    return 3 * cw + 3;
  endfunction

  // MSB index of a colour slice: ch 0 = R, 1 = G, 2 = B.
  function automatic int ch_msb(input int cw, input int ch);
    return (3 - ch) * cw - 1;
  endfunction

endpackage

// File: rtl/n64_deblur_grad.sv
// Per-channel gradient tracker: stores one pixel-pair gradient, flags a reversal on the next pair.
// Latency: 1 VCLK from strobe to updated gradient / reversal flag.
// Backpressure: none; strobes are single-cycle qualifiers from the word phase.
module n64_deblur_grad
  import n64_deblur_est_pkg::*;
#(
  parameter int CMP_BITS = 3
) (
  input  logic                VCLK,
  input  logic                nRST,
  input  logic [CMP_BITS-1:0] pre_i,
  input  logic [CMP_BITS-1:0] cur_i,
  input  logic                cap_i,
  input  logic                eval_i,
  input  logic                clr_i,
  output logic                rev_o
);

  logic [1:0] grad_new;
  logic [1:0] grad_q, grad_d;
  logic       rev_q, rev_d;

  // Gradient of the truncated channel value between previous and current pixel.
  always_comb begin
    grad_new = {(pre_i < cur_i), (pre_i > cur_i)};
  end

  // Capture a gradient on blur pixels; flag opposite non-flat gradients on the partner pixel.
  always_comb begin
    grad_d = grad_q;
    rev_d  = rev_q;
    if (cap_i) begin
      grad_d = grad_new;
    end
    if (clr_i) begin
      rev_d = 1'b0;
    end else if (eval_i && (((grad_q == GRAD_RISE) && (grad_new == GRAD_FALL)) ||
                            ((grad_q == GRAD_FALL) && (grad_new == GRAD_RISE)))) begin
      rev_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      grad_q <= GRAD_FLAT;
      rev_q  <= 1'b0;
    end else begin
      grad_q <= grad_d;
      rev_q  <= rev_d;
    end
  end

  assign rev_o = rev_q;

endmodule

// File: rtl/n64_deblur_est.sv
// Per-frame N64 blur classifier: counts RGB gradient reversals, filters votes into a trend, drives ndo_deblur.
// Latency: estimate lags its vote by one frame; ndo_deblur picks it up at the following nVSYNC fall.
// Backpressure: none; build option N64_DEBLUR_HYST_EN selects threshold hysteresis on the trend.
module n64_deblur_est
  import n64_deblur_est_pkg::*;
#(
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int CMP_BITS = 3,
  parameter int HIT_W    = 4,
  parameter int HIT_TH   = 15,
  parameter int TREND_W  = 9,
  parameter int TH_HI    = 'h140,
  parameter int TH_LO    = 'h0C0
) (
  input  logic                 VCLK,
  input  logic                 nRST,
  input  logic                 nVDSYNC,
  input  logic [COLOR_W-1:0]   VD_i,
  input  logic [3*COLOR_W+3:0] vdata_pre,
  input  logic [1:0]           data_cnt,
  input  logic                 vmode,
  input  logic                 n64_480i,
  input  logic                 nForceDeBlur,
  input  logic                 nDeBlurMan,
  output logic                 nblur_n64,
  output logic [TREND_W-1:0]   trend_o,
  output logic                 ndo_deblur
);

  // Trend starts at mid-scale so the estimate begins undecided with blur off.
  localparam logic [TREND_W-1:0] TREND_INIT = {1'b1, {(TREND_W-1){1'b0}}};
  localparam logic [TREND_W-1:0] TREND_MAX  = '1;
  localparam logic [TREND_W-1:0] TREND_MIN  = '0;
  localparam logic [TREND_W-1:0] TREND_ONE  = TREND_W'(1);
  localparam logic [HIT_W-1:0]   HIT_MAX    = '1;
  localparam logic [HIT_W-1:0]   HIT_ONE    = HIT_W'(1);
  localparam logic [HIT_W-1:0]   HIT_THR    = HIT_W'(HIT_TH);
  localparam int NCSYNC_IDX = idx_ncsync(COLOR_W);
  localparam int NVSYNC_IDX = idx_nvsync(COLOR_W);

  logic                sync_word, data_word;
  logic                ncsync_rise, nvsync_fall, frame_bnd;
  logic                hit_inc, clr;
  logic [2:0]          sel, rev;
  logic [CMP_BITS-1:0] cur_msb;
  logic                blur_pix_q, blur_pix_d;
  logic                run_est_q, run_est_d;
  logic                nblur_q, nblur_d;
  logic                ndo_q, ndo_d;
  logic [HIT_W-1:0]    hits_q, hits_d;
  logic [TREND_W-1:0]  trend_q, trend_d;
  logic                unused_bits;

  assign sync_word   = ~nVDSYNC;
  assign data_word   = nVDSYNC;
  assign ncsync_rise = sync_word & VD_i[0] & ~vdata_pre[NCSYNC_IDX];
  assign nvsync_fall = sync_word & ~VD_i[3] & vdata_pre[NVSYNC_IDX];
  assign frame_bnd   = nvsync_fall & ~n64_480i;
  assign cur_msb     = VD_i[COLOR_W-1 -: CMP_BITS];
  assign clr         = sync_word & ~blur_pix_q;
  assign hit_inc     = clr & (rev == 3'b111) & ~n64_480i;

  // Sync bits, colour LSBs and the threshold ordering are only partly consumed here.
  assign unused_bits = (^{vdata_pre, VD_i}) ^ (TH_LO < TH_HI);

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    assign sel[ch] = data_word & (data_cnt == 2'(ch + 1));
    n64_deblur_grad #(
      .CMP_BITS(CMP_BITS)
    ) u_grad (
      .VCLK   (VCLK),
      .nRST   (nRST),
      .pre_i  (vdata_pre[ch_msb(COLOR_W, ch) -: CMP_BITS]),
      .cur_i  (cur_msb),
      .cap_i  (sel[ch] & blur_pix_q),
      .eval_i (sel[ch] & ~blur_pix_q),
      .clr_i  (clr),
      .rev_o  (rev[ch])
    );
  end

  // Pixel-pair phase, hit counter, arming and trend filter next state.
  always_comb begin
    blur_pix_d = blur_pix_q;
    hits_d     = hits_q;
    run_est_d  = run_est_q;
    trend_d    = trend_q;
    if (sync_word) begin
      blur_pix_d = ncsync_rise ? ~vmode : ~blur_pix_q;
    end
    // A boundary clears hits even if a hit lands in the same cycle.
    if (frame_bnd) begin
      hits_d = '0;
    end else if (hit_inc && (hits_q != HIT_MAX)) begin
      hits_d = hits_q + HIT_ONE;
    end
    if (n64_480i) begin
      run_est_d = 1'b0;
    end else if (frame_bnd) begin
      run_est_d = 1'b1;
    end
    if (frame_bnd && run_est_q) begin
      if (hits_q >= HIT_THR) begin
        if (trend_q != TREND_MAX) trend_d = trend_q + TREND_ONE;
      end else begin
        if (trend_q != TREND_MIN) trend_d = trend_q - TREND_ONE;
      end
    end
  end

  // Estimate follows the trend as it stood before this boundary's vote.
  always_comb begin
    nblur_d = nblur_q;
    if (frame_bnd && run_est_q) begin
`ifdef N64_DEBLUR_HYST_EN
      if (trend_q >= TREND_W'(TH_HI)) begin
        nblur_d = 1'b1;
      end else if (trend_q <= TREND_W'(TH_LO)) begin
        nblur_d = 1'b0;
      end
`else
      nblur_d = trend_q[TREND_W-1];
`endif
    end
  end

  // Deblur control is resampled on every vertical sync, including 480i and override.
  always_comb begin
    ndo_d = ndo_q;
    if (nvsync_fall) begin
      ndo_d = n64_480i | (nForceDeBlur ? nblur_q : nDeBlurMan);
    end
  end

  // State registers; reset takes priority over any update in the same cycle.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      blur_pix_q <= 1'b0;
      hits_q     <= '0;
      run_est_q  <= 1'b0;
      trend_q    <= TREND_INIT;
      nblur_q    <= 1'b1;
      ndo_q      <= 1'b1;
    end else begin
      blur_pix_q <= blur_pix_d;
      hits_q     <= hits_d;
      run_est_q  <= run_est_d;
      trend_q    <= trend_d;
      nblur_q    <= nblur_d;
      ndo_q      <= ndo_d;
    end
  end

  assign nblur_n64  = nblur_q;
  assign trend_o    = trend_q;
  assign ndo_deblur = ndo_q;

endmodule

// File: tb/tb_n64_deblur_est.sv
// Directed bench for n64_deblur_est: frame-level table of stimulus with hand-computed results.
// Latency: checks are taken 1 time unit after the edge that ends each frame or sequence.
// Backpressure: none; every frame is a fixed number of words.
module tb_n64_deblur_est;

  logic        VCLK = 1'b0;
  logic        nRST;
  logic        nVDSYNC;
  logic [6:0]  VD_i;
  logic [24:0] vdata_pre;
  logic [1:0]  data_cnt;
  logic        vmode;
  logic        n64_480i;
  logic        nForceDeBlur;
  logic        nDeBlurMan;
  logic        nblur_n64;
  logic [8:0]  trend_o;
  logic        ndo_deblur;

  always #5 VCLK = ~VCLK;

  n64_deblur_est dut (
    .VCLK         (VCLK),
    .nRST         (nRST),
    .nVDSYNC      (nVDSYNC),
    .VD_i         (VD_i),
    .vdata_pre    (vdata_pre),
    .data_cnt     (data_cnt),
    .vmode        (vmode),
    .n64_480i     (n64_480i),
    .nForceDeBlur (nForceDeBlur),
    .nDeBlurMan   (nDeBlurMan),
    .nblur_n64    (nblur_n64),
    .trend_o      (trend_o),
    .ndo_deblur   (ndo_deblur)
  );

  int errors = 0;
  int checks = 0;

  // Previous pixel as seen on vdata_pre: {nVSYNC,nCLAMP,nHSYNC,nCSYNC}, R, G, B.
  logic [3:0] prev_sync;
  logic [6:0] prev_r, prev_g, prev_b;

  localparam int PAT_FLAT    = 0;
  localparam int PAT_SHARP   = 1;
  localparam int PAT_PARTIAL = 2;

  typedef struct {
    string      name;
    int         nfr;
    int         pat;
    int         npairs;
    logic       i480;
    logic       force_n;
    logic       man_n;
    logic [8:0] exp_trend;
    logic       exp_nblur;
    logic       exp_ndo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input int nfr, input int pat, input int np,
                     input logic i480, input logic fn, input logic mn,
                     input logic [8:0] et, input logic en, input logic ed);
    vec_t v;
    v.name = nm; v.nfr = nfr; v.pat = pat; v.npairs = np;
    v.i480 = i480; v.force_n = fn; v.man_n = mn;
    v.exp_trend = et; v.exp_nblur = en; v.exp_ndo = ed;
    tbl.push_back(v);
  endtask

  task automatic word(input logic nvd, input logic [6:0] vd, input logic [1:0] cnt);
    nVDSYNC   = nvd;
    VD_i      = vd;
    data_cnt  = cnt;
    vdata_pre = {prev_sync, prev_r, prev_g, prev_b};
    @(posedge VCLK);
    #1;
  endtask

  task automatic pix(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                     input logic [6:0] b);
    word(1'b0, {3'b000, s}, 2'd0);
    word(1'b1, r, 2'd1);
    word(1'b1, g, 2'd2);
    word(1'b1, b, 2'd3);
    prev_sync = s;
    prev_r = r;
    prev_g = g;
    prev_b = b;
  endtask

  // One frame: a vsync pixel (nVSYNC falls, nCSYNC low), then 2*npairs active pixels.
  task automatic frame(input int pat, input int npairs);
    logic [6:0] v;
    pix(4'b0110, 7'h00, 7'h00, 7'h00);
    for (int k = 1; k <= 2 * npairs; k++) begin
      v = ((k % 2 == 1) && (pat != PAT_FLAT)) ? 7'h7F : 7'h00;
      pix(4'b1111, v, v, (pat == PAT_PARTIAL) ? 7'h00 : v);
    end
  endtask

  task automatic chk(input string nm, input logic [8:0] et, input logic en, input logic ed);
    checks++;
    if (trend_o !== et) begin
      errors++;
      $display("FAIL %s trend_o: got %h expected %h", nm, trend_o, et);
    end
    checks++;
    if (nblur_n64 !== en) begin
      errors++;
      $display("FAIL %s nblur_n64: got %b expected %b", nm, nblur_n64, en);
    end
    checks++;
    if (ndo_deblur !== ed) begin
      errors++;
      $display("FAIL %s ndo_deblur: got %b expected %b", nm, ndo_deblur, ed);
    end
  endtask

  initial begin
    // Frame-level vectors; each row's votes act on the previous row's last frame.
    add("arm",       1,   PAT_SHARP,   20, 1'b0, 1'b1, 1'b1, 9'h100, 1'b1, 1'b1);
    add("sharp64",   64,  PAT_SHARP,   20, 1'b0, 1'b1, 1'b1, 9'h140, 1'b1, 1'b1);
    add("flat_lag",  1,   PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h141, 1'b1, 1'b1);
    add("flat_0ff",  66,  PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h0FF, 1'b1, 1'b1);
`ifdef N64_DEBLUR_HYST_EN
    add("flat_lo",   63,  PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h0C0, 1'b1, 1'b1);
    add("nblur_dn",  1,   PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h0BF, 1'b0, 1'b1);
    add("ndo_dn",    1,   PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h0BE, 1'b0, 1'b0);
`else
    add("nblur_dn",  1,   PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h0FE, 1'b0, 1'b1);
    add("ndo_dn",    1,   PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h0FD, 1'b0, 1'b0);
    add("flat_more", 1,   PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h0FC, 1'b0, 1'b0);
`endif
    add("sat_up",    330, PAT_SHARP,   16, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b1, 1'b1);
    add("sat_hold",  3,   PAT_SHARP,   16, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b1, 1'b1);
    add("man_on",    1,   PAT_SHARP,   20, 1'b0, 1'b0, 1'b0, 9'h1FF, 1'b1, 1'b0);
    add("man_off",   1,   PAT_SHARP,   20, 1'b0, 1'b0, 1'b1, 9'h1FF, 1'b1, 1'b1);
    add("partial",   1,   PAT_PARTIAL, 20, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b1, 1'b1);
    add("part_vote", 1,   PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h1FE, 1'b1, 1'b1);
    add("sat_dn",    600, PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0);
    add("sat_dn_h",  3,   PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0);
    add("i480",      3,   PAT_SHARP,   20, 1'b1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b1);
    add("rearm",     1,   PAT_SHARP,   20, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0);
    add("vote_up",   1,   PAT_SHARP,   20, 1'b0, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0);
    add("hits_15",   1,   PAT_SHARP,   15, 1'b0, 1'b1, 1'b1, 9'h002, 1'b0, 1'b0);
    add("hits_14",   1,   PAT_FLAT,    1,  1'b0, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0);

    // Idle, then reset.
    prev_sync    = 4'b1111;
    prev_r       = 7'h00;
    prev_g       = 7'h00;
    prev_b       = 7'h00;
    nRST         = 1'b0;
    vmode        = 1'b0;
    n64_480i     = 1'b0;
    nForceDeBlur = 1'b1;
    nDeBlurMan   = 1'b1;
    nVDSYNC      = 1'b1;
    VD_i         = 7'h00;
    data_cnt     = 2'd0;
    vdata_pre    = '0;
    for (int i = 0; i < 4; i++) word(1'b1, 7'h00, 2'd0);
    nRST = 1'b1;
    word(1'b1, 7'h00, 2'd0);
    chk("reset", 9'h100, 1'b1, 1'b1);

    foreach (tbl[i]) begin
      n64_480i     = tbl[i].i480;
      nForceDeBlur = tbl[i].force_n;
      nDeBlurMan   = tbl[i].man_n;
      for (int f = 0; f < tbl[i].nfr; f++) frame(tbl[i].pat, tbl[i].npairs);
      chk(tbl[i].name, tbl[i].exp_trend, tbl[i].exp_nblur, tbl[i].exp_ndo);
    end

    // Reset coinciding with a frame boundary wins over the vote and the ndo update.
    nRST = 1'b0;
    pix(4'b0110, 7'h00, 7'h00, 7'h00);
    nRST = 1'b1;
    chk("rst_mid", 9'h100, 1'b1, 1'b1);
    pix(4'b1111, 7'h00, 7'h00, 7'h00);
    frame(PAT_SHARP, 20);
    chk("rst_arm", 9'h100, 1'b1, 1'b1);
    frame(PAT_SHARP, 20);
    chk("rst_vote", 9'h101, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
